// File: rtl/button_press_classifier.sv
// Classifies gestures on a debounced button level into single-cycle short, double or long pulses.
// One shared counter times both the long-hold threshold and the double-press gap.
module button_press_classifier #(
    parameter int unsigned LONG_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 12_500_000,
    parameter int unsigned CNT_WIDTH   = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic debounced,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic held
);

    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        StIdle,
        StPress1,
        StWait2,
        StPress2,
        StLongHeld
    } state_e;

    state_e               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 prev;
    logic                 rise;
    logic                 fall;

    assign rise = debounced & ~prev;
    assign fall = ~debounced & prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            cnt          <= '0;
            // A button held through reset must be released before it can start a gesture.
            prev         <= 1'b1;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            held         <= 1'b0;
        end else begin
            prev         <= debounced;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (rise) begin
                        state <= StPress1;
                        cnt   <= '0;
                    end
                end
                StPress1: begin
                    if (fall) begin
                        state <= StWait2;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= StLongHeld;
                        cnt        <= '0;
                        long_press <= 1'b1;
                        held       <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                StWait2: begin
                    // A rise on the final gap cycle still counts as the second press.
                    if (rise) begin
                        state <= StPress2;
                        cnt   <= '0;
                    end else if (cnt == GAP_LAST) begin
                        state       <= StIdle;
                        cnt         <= '0;
                        short_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                StPress2: begin
                    if (fall) begin
                        state        <= StIdle;
                        cnt          <= '0;
                        double_press <= 1'b1;
                    end
                end
                StLongHeld: begin
                    if (fall) begin
                        state <= StIdle;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// Randomized scoreboard bench: gestures are described by their segment lengths and the expected
// event kind and edge are computed arithmetically; a monitor pops and checks each observed pulse.
module tb_button_press_classifier;

    localparam int L = 20;
    localparam int G = 10;

    localparam int K_SHORT  = 0;
    localparam int K_DOUBLE = 1;
    localparam int K_LONG   = 2;

    typedef struct {
        int kind;
        int at_edge;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic debounced;
    logic short_press;
    logic double_press;
    logic long_press;
    logic held;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    int   held_lo = 1;
    int   held_hi = 0;

    button_press_classifier #(
        .LONG_CYCLES(L),
        .GAP_CYCLES (G),
        .CNT_WIDTH  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .debounced   (debounced),
        .short_press (short_press),
        .double_press(double_press),
        .long_press  (long_press),
        .held        (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled at negedge, cyc equals the number of the edge just taken.
    always @(negedge clk) begin
        logic exp_held;
        int   kind;
        exp_t e;
        exp_held = (cyc >= held_lo) && (cyc <= held_hi);
        tests++;
        if (held !== exp_held) begin
            fails++;
            $display("FAIL held at edge %0d: got %b expected %b", cyc, held, exp_held);
        end
        if (short_press || double_press || long_press) begin
            tests++;
            kind = long_press ? K_LONG : (double_press ? K_DOUBLE : K_SHORT);
            if ((int'(short_press) + int'(double_press) + int'(long_press)) != 1) begin
                fails++;
                $display("FAIL onehot at edge %0d: got s=%b d=%b l=%b expected one pulse",
                         cyc, short_press, double_press, long_press);
            end else if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse at edge %0d: got kind %0d expected none",
                         cyc, kind);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != kind || e.at_edge != cyc) begin
                    fails++;
                    $display("FAIL pulse: got kind %0d at edge %0d expected kind %0d at edge %0d",
                             kind, cyc, e.kind, e.at_edge);
                end
            end
        end
    end

    // Drive v for n edges; on entry the first edge sampling v is cyc+1.
    task automatic hold_level(input logic v, input int n);
        debounced = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int kind, input int at_edge);
        exp_t e;
        e.kind    = kind;
        e.at_edge = at_edge;
        exp_q.push_back(e);
    endtask

    // Press p, release g; if it forms a double press, press again q and release r.
    task automatic gesture(input int p, input int g, input int q, input int r);
        int t0;
        int tf;
        t0 = cyc + 1;
        if (p > L) begin
            push_exp(K_LONG, t0 + L);
            held_lo = t0 + L;
            held_hi = t0 + p - 1;
            hold_level(1'b1, p);
            hold_level(1'b0, g);
        end else begin
            tf = t0 + p;
            if (g <= G) begin
                push_exp(K_DOUBLE, tf + g + q);
                hold_level(1'b1, p);
                hold_level(1'b0, g);
                hold_level(1'b1, q);
                hold_level(1'b0, r);
            end else begin
                push_exp(K_SHORT, tf + G);
                hold_level(1'b1, p);
                hold_level(1'b0, g);
            end
        end
    endtask

    initial begin
        int p;
        int g;
        reset     = 1'b1;
        debounced = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if ({short_press, double_press, long_press, held} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_state: got %b expected 0000",
                     {short_press, double_press, long_press, held});
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Held through reset: neither the hold nor its release is a gesture.
        hold_level(1'b1, 30);
        hold_level(1'b0, 15);

        gesture(5, 15, 0, 0);
        gesture(5, 4, 3, 2);
        gesture(40, 3, 0, 0);
        gesture(L, G + 1, 0, 0);
        gesture(5, G, 4, 1);
        gesture(L + 1, 1, 0, 0);
        gesture(3, 2, 35, 1);

        // Reset during the gap discards the gesture.
        hold_level(1'b1, 5);
        hold_level(1'b0, 3);
        reset = 1'b1;
        hold_level(1'b0, 2);
        reset = 1'b0;
        hold_level(1'b0, 20);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       p = L;
                1:       p = L + 1;
                default: p = $urandom_range(1, L + 15);
            endcase
            if (p > L) begin
                gesture(p, $urandom_range(1, 5), 0, 0);
            end else begin
                g = ($urandom_range(0, 3) == 0) ? G : $urandom_range(1, G + 4);
                gesture(p, g, $urandom_range(1, 30), $urandom_range(1, 4));
            end
        end

        hold_level(1'b0, G + 5);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_pulses: got %0d outstanding expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
